// File: rtl/eth_pkg.sv
// Types and constants shared by the Ethernet TX scheduler and the frame sender.
package eth_pkg;

    localparam logic [3:0] PKT_NONE     = 4'd0;
    localparam logic [3:0] PKT_ARP_REQ  = 4'd1;
    localparam logic [3:0] PKT_ARP_RESP = 4'd2;
    localparam logic [3:0] PKT_UDP      = 4'd3;

    localparam int WD_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2
    } state_t;

endpackage

// File: rtl/eth_tx_watchdog.sv
// Clear/enable saturating cycle counter; o_expire flags when the count sits at i_limit.
module eth_tx_watchdog
    import eth_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic [WD_W-1:0] i_limit,
    output logic            o_expire
);

    logic [WD_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != {WD_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expire = (r_cnt == i_limit);

endmodule

// File: rtl/eth_tx_sched.sv
// Fixed-priority packet-type scheduler for the Ethernet frame sender with
// atomic multi-fragment UDP bursts and SOP/EOP watchdogs.
module eth_tx_sched
    import eth_pkg::*;
#(
    parameter int UDP_FRAGS   = 4,
    parameter int SOP_TIMEOUT = 64,
    parameter int EOP_TIMEOUT = 2048
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_msync_n,
    input  logic       i_udp_en,
    input  logic       i_arp_req,
    input  logic       i_arp_resp_req,
    input  logic       i_tx_sop,
    input  logic       i_tx_eop,
    output logic [3:0] o_pkt_type,
    output logic       o_busy,
    output logic       o_udp_active,
    output logic [2:0] o_frag_cnt,
    output logic       o_err_timeout,
    output logic       o_udp_overrun
);

    if (UDP_FRAGS < 1 || UDP_FRAGS > 7) begin : g_bad_frags
        $error("eth_tx_sched: UDP_FRAGS must be in 1..7");
    end

    localparam logic [2:0]      FRAGS     = 3'(UDP_FRAGS);
    localparam logic [WD_W-1:0] SOP_LIMIT = WD_W'(SOP_TIMEOUT - 1);
    localparam logic [WD_W-1:0] EOP_LIMIT = WD_W'(EOP_TIMEOUT - 1);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_pkt_type, w_pkt_nxt;
    logic       r_udp_active, w_active_nxt;
    logic [2:0] r_frag_cnt, w_frag_nxt;
    logic       r_err, w_err_nxt;
    logic       r_overrun;
    logic       r_msync_n;
    logic       r_pend_resp, r_pend_req, r_pend_udp;

    logic       w_msync_fall, w_overrun;
    logic       w_idle, w_gnt_resp, w_gnt_udp, w_gnt_req;
    logic       w_eop, w_wd_clr, w_wd_exp;
    logic [2:0] w_frag_inc;

    assign w_msync_fall = r_msync_n & ~i_msync_n;
    assign w_overrun    = w_msync_fall & r_udp_active;

    assign w_idle     = (r_state == IDLE);
    assign w_gnt_resp = w_idle & r_pend_resp;
    assign w_gnt_udp  = w_idle & ~r_pend_resp & r_pend_udp;
    assign w_gnt_req  = w_idle & ~r_pend_resp & ~r_pend_udp & r_pend_req;

    // A sop+eop in the same ISSUE cycle is a single-beat frame: handle its eop now.
    assign w_eop = ((r_state == ISSUE) & i_tx_sop & i_tx_eop) | ((r_state == XFER) & i_tx_eop);

    assign w_wd_clr = w_idle | ((r_state == ISSUE) & i_tx_sop) | ((r_state == XFER) & i_tx_eop);
    assign w_frag_inc = r_frag_cnt + 3'd1;

    eth_tx_watchdog u_wd (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_wd_clr),
        .i_en     (~w_wd_clr),
        .i_limit  ((r_state == ISSUE) ? SOP_LIMIT : EOP_LIMIT),
        .o_expire (w_wd_exp)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_pkt_nxt    = r_pkt_type;
        w_active_nxt = r_udp_active;
        w_frag_nxt   = r_frag_cnt;
        w_err_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_resp) begin
                    w_state_nxt = ISSUE;
                    w_pkt_nxt   = PKT_ARP_RESP;
                end else if (w_gnt_udp) begin
                    w_state_nxt  = ISSUE;
                    w_pkt_nxt    = PKT_UDP;
                    w_active_nxt = 1'b1;
                    w_frag_nxt   = 3'd0;
                end else if (w_gnt_req) begin
                    w_state_nxt = ISSUE;
                    w_pkt_nxt   = PKT_ARP_REQ;
                end
            end
            ISSUE: begin
                if (i_tx_sop) begin
                    w_state_nxt = XFER;
                    w_pkt_nxt   = PKT_NONE;
                end else if (w_wd_exp) begin
                    w_state_nxt  = IDLE;
                    w_pkt_nxt    = PKT_NONE;
                    w_active_nxt = 1'b0;
                    w_err_nxt    = 1'b1;
                end
            end
            XFER: begin
                if (!i_tx_eop && w_wd_exp) begin
                    w_state_nxt  = IDLE;
                    w_pkt_nxt    = PKT_NONE;
                    w_active_nxt = 1'b0;
                    w_err_nxt    = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Fragment bookkeeping; an overrun restarts the count and keeps the burst going.
        if (w_eop) begin
            if (!r_udp_active) begin
                w_state_nxt = IDLE;
            end else begin
                w_frag_nxt = w_frag_inc;
                if (w_frag_inc == FRAGS && !w_overrun) begin
                    w_state_nxt  = IDLE;
                    w_active_nxt = 1'b0;
                end else begin
                    w_state_nxt = ISSUE;
                    w_pkt_nxt   = PKT_UDP;
                end
            end
        end
        if (w_overrun)
            w_frag_nxt = 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pkt_type   <= PKT_NONE;
            r_udp_active <= 1'b0;
            r_frag_cnt   <= 3'd0;
            r_err        <= 1'b0;
            r_overrun    <= 1'b0;
            r_msync_n    <= 1'b1;
            r_pend_resp  <= 1'b0;
            r_pend_req   <= 1'b0;
            r_pend_udp   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pkt_type   <= w_pkt_nxt;
            r_udp_active <= w_active_nxt;
            r_frag_cnt   <= w_frag_nxt;
            r_err        <= w_err_nxt;
            r_overrun    <= w_overrun;
            r_msync_n    <= i_msync_n;
            r_pend_resp  <= i_arp_resp_req | (r_pend_resp & ~w_gnt_resp);
            r_pend_req   <= i_arp_req | (r_pend_req & ~w_gnt_req);
            r_pend_udp   <= (w_msync_fall & i_udp_en & ~r_udp_active) | (r_pend_udp & ~w_gnt_udp);
        end
    end

    assign o_pkt_type    = r_pkt_type;
    assign o_busy        = (r_state != IDLE);
    assign o_udp_active  = r_udp_active;
    assign o_frag_cnt    = r_frag_cnt;
    assign o_err_timeout = r_err;
    assign o_udp_overrun = r_overrun;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched: priorities, UDP bursts, watchdog, overrun, reset.
module tb_eth_tx_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_msync_n = 1'b1;
    logic       i_udp_en = 1'b0;
    logic       i_arp_req = 1'b0;
    logic       i_arp_resp_req = 1'b0;
    logic       i_tx_sop = 1'b0;
    logic       i_tx_eop = 1'b0;
    logic [3:0] o_pkt_type;
    logic       o_busy;
    logic       o_udp_active;
    logic [2:0] o_frag_cnt;
    logic       o_err_timeout;
    logic       o_udp_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    eth_tx_sched dut (
        .clk            (clk),
        .rst            (rst),
        .i_msync_n      (i_msync_n),
        .i_udp_en       (i_udp_en),
        .i_arp_req      (i_arp_req),
        .i_arp_resp_req (i_arp_resp_req),
        .i_tx_sop       (i_tx_sop),
        .i_tx_eop       (i_tx_eop),
        .o_pkt_type     (o_pkt_type),
        .o_busy         (o_busy),
        .o_udp_active   (o_udp_active),
        .o_frag_cnt     (o_frag_cnt),
        .o_err_timeout  (o_err_timeout),
        .o_udp_overrun  (o_udp_overrun)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({o_pkt_type, o_busy, o_udp_active, o_frag_cnt, o_err_timeout, o_udp_overrun} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pkt=%0d busy=%0b act=%0b frag=%0d err=%0b ovr=%0b expected all 0",
                     o_pkt_type, o_busy, o_udp_active, o_frag_cnt, o_err_timeout, o_udp_overrun);
        end
        rst = 1'b0;
        i_tx_sop = 1'b1;
        i_tx_eop = 1'b1;
        tick();
        i_tx_sop = 1'b0;
        i_tx_eop = 1'b0;
        tick();
        n_checks++;
        if (o_busy !== 1'b0 || o_pkt_type !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_ignores_sop_eop: got busy=%0b pkt=%0d expected 0/0", o_busy, o_pkt_type);
        end
    endtask

    task automatic test_arp_resp();
        bit bad;
        i_arp_resp_req = 1'b1;
        tick();
        i_arp_resp_req = 1'b0;
        n_checks++;
        if (o_pkt_type !== 4'd0) begin
            n_fail++;
            $display("FAIL resp_latency1: got %0d expected 0", o_pkt_type);
        end
        tick();
        n_checks++;
        if (o_pkt_type !== 4'd2 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_issue: got pkt=%0d busy=%0b expected 2/1", o_pkt_type, o_busy);
        end
        bad = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (o_pkt_type !== 4'd2) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL resp_hold: pkt left 2 before sop, now %0d", o_pkt_type);
        end
        i_tx_sop = 1'b1;
        tick();
        i_tx_sop = 1'b0;
        n_checks++;
        if (o_pkt_type !== 4'd0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_xfer: got pkt=%0d busy=%0b expected 0/1", o_pkt_type, o_busy);
        end
        for (int i = 0; i < 10; i++) tick();
        i_tx_eop = 1'b1;
        tick();
        i_tx_eop = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_pkt_type !== 4'd0) begin
            n_fail++;
            $display("FAIL resp_done: got busy=%0b pkt=%0d expected 0/0", o_busy, o_pkt_type);
        end
    endtask

    task automatic test_priority();
        i_arp_req = 1'b1;
        i_arp_resp_req = 1'b1;
        tick();
        i_arp_req = 1'b0;
        i_arp_resp_req = 1'b0;
        tick();
        n_checks++;
        if (o_pkt_type !== 4'd2) begin
            n_fail++;
            $display("FAIL prio_first: got %0d expected 2", o_pkt_type);
        end
        // single-beat frame: sop and eop together
        i_tx_sop = 1'b1;
        i_tx_eop = 1'b1;
        tick();
        i_tx_sop = 1'b0;
        i_tx_eop = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_pkt_type !== 4'd0) begin
            n_fail++;
            $display("FAIL prio_single_beat: got busy=%0b pkt=%0d expected 0/0", o_busy, o_pkt_type);
        end
        tick();
        n_checks++;
        if (o_pkt_type !== 4'd1) begin
            n_fail++;
            $display("FAIL prio_second: got %0d expected 1", o_pkt_type);
        end
        i_tx_sop = 1'b1;
        tick();
        i_tx_sop = 1'b0;
        i_tx_eop = 1'b1;
        tick();
        i_tx_eop = 1'b0;
        tick();
        n_checks++;
        if (o_busy !== 1'b0 || o_pkt_type !== 4'd0) begin
            n_fail++;
            $display("FAIL prio_drained: got busy=%0b pkt=%0d expected 0/0", o_busy, o_pkt_type);
        end
    endtask

    // One sender frame on a UDP fragment; checks count and reissue afterwards.
    task automatic udp_frame(input int n, input bit last);
        i_tx_sop = 1'b1;
        tick();
        i_tx_sop = 1'b0;
        tick();
        i_tx_eop = 1'b1;
        tick();
        i_tx_eop = 1'b0;
        n_checks++;
        if (o_frag_cnt !== 3'(n) || o_udp_active !== !last || o_pkt_type !== (last ? 4'd0 : 4'd3)) begin
            n_fail++;
            $display("FAIL udp_frag%0d: got frag=%0d act=%0b pkt=%0d expected %0d/%0b/%0d",
                     n, o_frag_cnt, o_udp_active, o_pkt_type, n, !last, last ? 0 : 3);
        end
    endtask

    task automatic start_burst();
        i_msync_n = 1'b0;
        tick();
        i_msync_n = 1'b1;
        tick();
        n_checks++;
        if (o_pkt_type !== 4'd3 || o_udp_active !== 1'b1 || o_frag_cnt !== 3'd0) begin
            n_fail++;
            $display("FAIL udp_start: got pkt=%0d act=%0b frag=%0d expected 3/1/0",
                     o_pkt_type, o_udp_active, o_frag_cnt);
        end
    endtask

    task automatic test_udp_burst();
        i_udp_en = 1'b1;
        start_burst();
        i_arp_resp_req = 1'b1;
        tick();
        i_arp_resp_req = 1'b0;
        for (int i = 1; i <= 4; i++) udp_frame(i, i == 4);
        tick();
        n_checks++;
        if (o_pkt_type !== 4'd2) begin
            n_fail++;
            $display("FAIL udp_then_resp: got %0d expected 2", o_pkt_type);
        end
        i_tx_sop = 1'b1;
        i_tx_eop = 1'b1;
        tick();
        i_tx_sop = 1'b0;
        i_tx_eop = 1'b0;
    endtask

    task automatic test_sop_timeout();
        bit bad;
        i_arp_req = 1'b1;
        tick();
        i_arp_req = 1'b0;
        tick();
        n_checks++;
        if (o_pkt_type !== 4'd1) begin
            n_fail++;
            $display("FAIL tmo_issue: got %0d expected 1", o_pkt_type);
        end
        bad = 1'b0;
        for (int i = 1; i < 64; i++) begin
            tick();
            if (o_err_timeout !== 1'b0 || o_pkt_type !== 4'd1) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL tmo_early: err=%0b pkt=%0d before 64 cycles", o_err_timeout, o_pkt_type);
        end
        tick();
        n_checks++;
        if (o_err_timeout !== 1'b1 || o_pkt_type !== 4'd0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_expire: got err=%0b pkt=%0d busy=%0b expected 1/0/0",
                     o_err_timeout, o_pkt_type, o_busy);
        end
        tick();
        n_checks++;
        if (o_err_timeout !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_pulse: got err=%0b busy=%0b expected 0/0", o_err_timeout, o_busy);
        end
    endtask

    task automatic test_overrun();
        start_burst();
        udp_frame(1, 1'b0);
        udp_frame(2, 1'b0);
        i_msync_n = 1'b0;
        tick();
        i_msync_n = 1'b1;
        n_checks++;
        if (o_udp_overrun !== 1'b1 || o_frag_cnt !== 3'd0 || o_udp_active !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_pulse: got ovr=%0b frag=%0d act=%0b expected 1/0/1",
                     o_udp_overrun, o_frag_cnt, o_udp_active);
        end
        tick();
        n_checks++;
        if (o_udp_overrun !== 1'b0 || o_pkt_type !== 4'd3) begin
            n_fail++;
            $display("FAIL ovr_once: got ovr=%0b pkt=%0d expected 0/3", o_udp_overrun, o_pkt_type);
        end
        for (int i = 1; i <= 4; i++) udp_frame(i, i == 4);
        tick();
        n_checks++;
        if (o_busy !== 1'b0 || o_pkt_type !== 4'd0) begin
            n_fail++;
            $display("FAIL ovr_no_pend: got busy=%0b pkt=%0d expected 0/0", o_busy, o_pkt_type);
        end
    endtask

    task automatic test_rst_mid();
        start_burst();
        i_tx_sop = 1'b1;
        tick();
        i_tx_sop = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({o_pkt_type, o_busy, o_udp_active, o_frag_cnt, o_err_timeout, o_udp_overrun} !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got pkt=%0d busy=%0b act=%0b frag=%0d expected all 0",
                     o_pkt_type, o_busy, o_udp_active, o_frag_cnt);
        end
        start_burst();
        udp_frame(1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_arp_resp();
        test_priority();
        test_udp_burst();
        test_sop_timeout();
        test_overrun();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
- Scheduler in front of the Ethernet frame sender: decides which packet type the sender builds next and presents it on the sender's pkt_type input.
- Requesters are ARP reply, ARP request and the per-sync UDP data burst; arbitration is fixed priority.
- Tracks sender sop/eop to sequence multi-fragment UDP bursts atomically.
- Includes SOP/EOP watchdogs so a stalled sender cannot lock out the scheduler.

Parameters:
- UDP_FRAGS, 4, number of sender frames (eop events) that make up one UDP burst per sync period.
- SOP_TIMEOUT, 64, cycles allowed from issue to i_tx_sop.
- EOP_TIMEOUT, 2048, cycles allowed from i_tx_sop to i_tx_eop.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_msync_n  in  1  main sync, active low; its falling edge starts a UDP burst
- i_udp_en  in  1  UDP bursts enabled
- i_arp_req  in  1  pulse: send an ARP request
- i_arp_resp_req  in  1  pulse: an ARP request was received; send a reply
- i_tx_sop  in  1  sender start-of-packet strobe (valid with handshake)
- i_tx_eop  in  1  sender end-of-packet strobe
- o_pkt_type  out  4  type to sender: 0 none, 1 ARP request, 2 ARP reply, 3 UDP
- o_busy  out  1  state is not IDLE
- o_udp_active  out  1  UDP burst in progress
- o_frag_cnt  out  3  UDP fragments completed in the current burst
- o_err_timeout  out  1  one-cycle pulse on SOP or EOP watchdog expiry
- o_udp_overrun  out  1  one-cycle pulse when a sync edge arrives during a UDP burst

Behaviour:
- Reset values: all outputs 0, state IDLE, pending flags 0, watchdog 0. i_msync_n edge register resets to 1.
- Sync edge: msync_fall = prev_msync_n & ~i_msync_n, with prev_msync_n registered. It sets pend_udp only when i_udp_en = 1.
- Pending flags pend_resp, pend_req, pend_udp:
  - Each is set by its request pulse and cleared on grant.
  - A set in the same cycle as its grant wins, so the flag stays 1.
  - Repeated pulses while a flag is pending merge into it; there is no counting.
- Priority on grant: pend_resp > pend_udp > pend_req. Evaluated only in IDLE.
- IDLE:
  - If any flag is pending, go to ISSUE next cycle and register o_pkt_type with the winner's type.
  - A UDP grant sets o_udp_active = 1 and o_frag_cnt = 0.
- ISSUE:
  - o_pkt_type is held; the watchdog counts up.
  - On i_tx_sop: o_pkt_type <= 0 next cycle, go to XFER, clear the watchdog.
  - When the watchdog reaches SOP_TIMEOUT-1 without sop: pulse o_err_timeout, o_pkt_type <= 0, o_udp_active <= 0, go to IDLE. The granted request is dropped.
- XFER:
  - o_pkt_type = 0; the watchdog counts.
  - On i_tx_eop, non-UDP: go to IDLE.
  - On i_tx_eop, UDP: o_frag_cnt <= o_frag_cnt + 1.
    - If the new count equals UDP_FRAGS: o_udp_active <= 0, go to IDLE.
    - Otherwise go to ISSUE with o_pkt_type <= 3. The next fragment is issued without re-arbitration, so UDP bursts are atomic.
  - When the watchdog reaches EOP_TIMEOUT-1 without eop: pulse o_err_timeout, abort the burst, go to IDLE.
- Simultaneous sop and eop in the same cycle (degenerate single-beat frame): treat as sop followed immediately by eop handling, i.e. the same cycle acts as ISSUE→XFER→eop.
- msync_fall while o_udp_active = 1:
  - Pulse o_udp_overrun and reset o_frag_cnt to 0; the burst continues from the restart.
  - pend_udp is not set.
- msync_fall while pend_udp = 1 and not active: merged, no overrun pulse.
- i_tx_sop/i_tx_eop seen in IDLE are ignored.
- rst asserted mid-operation: everything returns to reset values on the next edge. The sender is expected to be reset on the same reset tree.
- Latency: request pulse to o_pkt_type valid is 2 cycles (flag set, then grant) when idle.
- Width rules:
  - The watchdog is 12 bits and saturates, never wrapping.
  - o_frag_cnt is 3 bits; UDP_FRAGS must be ≤ 7, enforced by a static assertion.

Decomposition:
- Shared package eth_pkg holds:
  - Packet-type constants PKT_NONE = 0, PKT_ARP_REQ = 1, PKT_ARP_RESP = 2, PKT_UDP = 3, also used by the sender.
  - State enum IDLE/ISSUE/XFER.
- One sub-module, eth_tx_watchdog: a clear/enable saturating counter with a limit input and an expire output. It is shared by the SOP and EOP checks, with the limit chosen by state.

Test Plan:
- i_arp_resp_req pulse at cycle 10, sop at 30, eop at 41 → o_pkt_type = 2 during cycles 12-30, then 0; o_busy falls after cycle 41.
- i_arp_req and i_arp_resp_req in the same cycle → ARP reply (2) issued first, then ARP request (1) after the first eop; no request lost.
- i_udp_en = 1, falling edge of msync, sender answers 4 sop/eop pairs → o_pkt_type = 3 reissued 4 times, o_frag_cnt steps 1..4, o_udp_active falls after the 4th eop. An i_arp_resp_req during the burst is served only afterwards.
- Issue ARP request, never assert sop → o_err_timeout pulses exactly 64 cycles after issue; state returns to IDLE with o_pkt_type = 0.
- msync_fall after fragment 2 of a burst → o_udp_overrun pulses once, o_frag_cnt returns to 0, and 4 further fragments complete.
- rst high for 1 cycle while in XFER of a UDP burst → all outputs 0 next cycle; a new msync edge then starts a fresh burst with o_frag_cnt = 0.
